// File: rtl/spi_flash_access_pkg.sv
// Shared types and byte-map constants for the SPI flash access arbiter.
package spi_flash_access_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    READB,
    DONE
  } state_t;

  localparam logic [31:0] RD_BYTE0  = 32'd0;
  localparam logic [31:0] WR_BYTE0  = 32'd4;
  localparam logic [31:0] PARK_ADDR = 32'd8;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; the last winner yields under contention.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       gnt_id,
  output logic       gnt_any
);

  logic last_grant;

  always_comb begin
    gnt_id = 1'b0;
    if (req[0] && req[1]) gnt_id = ~last_grant;
    else if (req[1])      gnt_id = 1'b1;
  end

  assign gnt_any = |req;

  // Resets to port 1 so port 0 wins the first simultaneous request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    last_grant <= 1'b1;
    else if (advance && gnt_any) last_grant <= gnt_id;
  end

endmodule

// File: rtl/spi_flash_access_arbiter.sv
// Sequences 32-bit word transfers through the byte-mapped SPI flash I/O block
// and shares it between the fetch (port 0) and data (port 1) requesters.
module spi_flash_access_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] PARK_ADDR      = spi_flash_access_pkg::PARK_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] io_address,
  output logic [7:0]  io_dataIn,
  input  logic [7:0]  io_dataOut,
  output logic        io_read,
  output logic        io_write,
  input  logic        io_ready
);
  import spi_flash_access_pkg::*;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t           state, state_nxt;
  logic [1:0]       k;
  logic [CNT_W-1:0] wait_cnt;
  logic             port_q, we_q, err_q;
  logic [31:0]      wdata_q;
  logic             gnt_id, gnt_any, advance, timeout;

  assign advance = (state == IDLE);
  assign timeout = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({req1, req0}),
    .advance (advance),
    .gnt_id  (gnt_id),
    .gnt_any (gnt_any)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (gnt_any) state_nxt = (gnt_id ? we1 : we0) ? LOAD : ISSUE;
      LOAD:      if (k == 2'd3) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (timeout)        state_nxt = DONE;
        else if (!io_ready) state_nxt = WAIT_DONE;
      end
      // A ready seen on the final wait cycle still counts as a clean finish.
      WAIT_DONE: begin
        if (io_ready)     state_nxt = we_q ? DONE : READB;
        else if (timeout) state_nxt = DONE;
      end
      READB:     if (k == 2'd3) state_nxt = DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k        <= 2'd0;
      wait_cnt <= '0;
      port_q   <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          k     <= 2'd0;
          err_q <= 1'b0;
          if (gnt_any) begin
            port_q <= gnt_id;
            we_q   <= gnt_id ? we1 : we0;
          end
        end
        LOAD, READB: k <= k + 2'd1;
        ISSUE:       wait_cnt <= '0;
        WAIT_BUSY, WAIT_DONE: begin
          wait_cnt <= wait_cnt + 1'b1;
          err_q    <= timeout && !(state == WAIT_DONE && io_ready);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && gnt_any) wdata_q <= gnt_id ? wdata1 : wdata0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata0 <= '0;
      rdata1 <= '0;
    end else if (state == READB) begin
      if (port_q) rdata1[{k, 3'b000} +: 8] <= io_dataOut;
      else        rdata0[{k, 3'b000} +: 8] <= io_dataOut;
    end
  end

  always_comb begin
    io_address = PARK_ADDR;
    io_dataIn  = 8'h00;
    io_read    = 1'b0;
    io_write   = 1'b0;
    done0      = 1'b0;
    done1      = 1'b0;
    err0       = 1'b0;
    err1       = 1'b0;
    case (state)
      LOAD: begin
        io_address = WR_BYTE0 + {30'd0, k};
        io_dataIn  = wdata_q[{k, 3'b000} +: 8];
      end
      ISSUE: begin
        io_write = we_q;
        io_read  = ~we_q;
      end
      READB: io_address = RD_BYTE0 + {30'd0, k};
      DONE: begin
        done0 = ~port_q;
        done1 = port_q;
        err0  = ~port_q & err_q;
        err1  = port_q & err_q;
      end
      default: ;
    endcase
  end

endmodule
